// File: rtl/synth_pkg.sv
// Shared constants for the ADSR envelope datapath: default nibble width and
// the named select codes used by callers of the 2:1 nibble selector.
package synth_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : synth_pkg

// File: rtl/mux_2input_4bit.sv
// Registered 2:1 selector for WIDTH-bit envelope control words: one register
// with the select in front, synchronous active-low reset, one cycle latency.
module mux_2input_4bit
  import synth_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] pick_s;
  logic [WIDTH-1:0] out_r;

  // Select the operand to be captured at the next edge.
  always_comb begin
    pick_s = a;
    if (sel == SEL_B) begin
      pick_s = b;
    end else begin
      pick_s = a;
    end
  end

  // Output register; reset wins over the select path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r <= {WIDTH{1'b0}};
    end else begin
      out_r <= pick_s;
    end
  end

  assign out = out_r;

endmodule : mux_2input_4bit

// File: tb/tb_mux_2input_4bit.sv
// Scoreboard bench for mux_2input_4bit: stimulus pushes expected values, a
// monitor pops and compares one edge later.
module tb_mux_2input_4bit;
  import synth_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel;
  logic [3:0] out;

  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;

  mux_2input_4bit #(.WIDTH(NIBBLE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what a registered selector must hold after the coming edge.
  function automatic logic [3:0] ref_out(input logic r, input logic [3:0] va,
                                         input logic [3:0] vb, input logic s);
    if (r == 1'b0) return 4'h0;
    return (s == SEL_B) ? vb : va;
  endfunction

  // Drive one cycle of inputs at the falling edge; optionally glitch sel
  // between edges, which must not be visible.
  task automatic step(input string tag, input logic r, input logic [3:0] va,
                      input logic [3:0] vb, input logic s, input bit glitch);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    a     = va;
    b     = vb;
    if (glitch) begin
      sel = ~s;
      #2;
      b   = ~vb;
      a   = ~va;
      #1;
      a   = va;
      b   = vb;
      sel = s;
    end else begin
      sel = s;
    end
    e.tag = tag;
    e.exp = ref_out(r, va, vb, s);
    sb_q.push_back(e);
  endtask

  // Monitor: compare just after each rising edge against the oldest entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (out !== e.exp) begin
        n_fail++;
        $display("FAIL %s: out=%h expected=%h at %0t", e.tag, out, e.exp, $time);
      end
    end
  end

  initial begin
    logic [3:0] ra, rb;
    int wait_cycles;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a       = 4'h0;
    b       = 4'h0;
    sel     = SEL_A;

    for (int i = 0; i < 3; i++) step("reset_hold", 1'b0, 4'hF, 4'hA, SEL_B, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step("sel_a", 1'b1, ra, rb, SEL_A, 1'b0);
    end
    // b alone changing while a is held
    for (int i = 0; i < 4; i++) begin
      rb = 4'($urandom_range(0, 15));
      step("sel_a_b_toggles", 1'b1, 4'h3, rb, SEL_A, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step("sel_b", 1'b1, ra, rb, SEL_B, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      ra = 4'($urandom_range(0, 15));
      step("sel_b_a_toggles", 1'b1, ra, 4'h9, SEL_B, 1'b0);
    end

    for (int i = 0; i < 4; i++) step("toggle", 1'b1, 4'h1, 4'hE, 1'(i % 2), 1'b0);

    step("midreset_pre",  1'b1, 4'h2, 4'h7, SEL_B, 1'b0);
    step("midreset_low",  1'b0, 4'h2, 4'h7, SEL_B, 1'b0);
    step("midreset_post", 1'b1, 4'h2, 4'h7, SEL_B, 1'b0);

    for (int i = 0; i < 8; i++) step("extremes", 1'b1, 4'h0, 4'hF, 1'(i % 2), 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step("random_mix", ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, ra, rb,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: pending=%0d required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_2input_4bit
